mcs_fpro_bridge_mc: RTL and testbench

Multi-region bridge from the MicroBlaze MCS I/O bus to the FPro bus, the successor to the fixed two-slot bridge. It sits between the `cpu` MCS core and up to `N_CS` FPro subsystems (mmio, video, future slots). It decodes a parametrised number of chip-select regions and registers every transaction. It supports slow slaves through a per-region ready handshake and a minimum read wait, and it bounds every access with a timeout that returns error data and sets a sticky error flag.

---
 rtl/mcs_brg_pkg.sv | 28 ++
 rtl/mcs_fpro_bridge_mc_timer.sv | 45 ++++
 rtl/mcs_fpro_bridge_mc.sv | 160 ++++++++++++++++
 tb/tb_mcs_fpro_bridge_mc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs_brg_pkg.sv
// mcs_brg_pkg
//   Shared types and helpers for the MCS-to-FPro multi-region bridge.
//   - brg_state_t    : bridge FSM state encoding
//   - BRG_ERR_DATA   : read data returned when an access times out
//   - brg_region_idx : chip-select region index taken from the top CSW bits
//                      of the 16 MB bridge window (io_address[23:24-CSW])
package mcs_brg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } brg_state_t;

  localparam logic [31:0] BRG_ERR_DATA = 32'hDEAD_BEEF;

  // Region bits always start at address bit 23; with at most eight regions
  // the index fits in three bits, so shift the top three bits down to keep
  // only the csw most significant ones.
  function automatic logic [2:0] brg_region_idx(input logic [31:0] addr,
                                                input int          csw);
    logic [2:0] top3;
    top3 = addr[23:21];
    return top3 >> (3 - csw);
  endfunction

endpackage

// File: rtl/mcs_fpro_bridge_mc_timer.sv
// brg_wait_timer
//   Saturating wait-cycle counter for the bridge WAIT state.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     clr         : force the count to zero (has priority over en)
//     en          : advance the count by one; holds at TIMEOUT
//     ge_rdwait   : count >= RD_WAIT (minimum read wait satisfied)
//     timeout     : count == TIMEOUT (access must be aborted)
module brg_wait_timer #(
  parameter int RD_WAIT = 0,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic ge_rdwait,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !timeout) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign timeout = (cnt == CW'(TIMEOUT));

  // With no minimum read wait the comparison is trivially true; tie it off
  // rather than building a constant unsigned compare.
  generate
    if (RD_WAIT == 0) begin : g_no_rdwait
      assign ge_rdwait = 1'b1;
    end else begin : g_rdwait
      assign ge_rdwait = (cnt >= CW'(RD_WAIT));
    end
  endgenerate

endmodule

// File: rtl/mcs_fpro_bridge_mc.sv
// mcs_fpro_bridge_mc
//   Bridge from the MicroBlaze MCS I/O bus to N_CS FPro chip-select regions.
//   Each accepted strobe runs IDLE -> ACCESS -> WAIT -> DONE (hits) or
//   IDLE -> DONE (misses). Slow slaves stretch WAIT through fp_rdy; every
//   access is bounded by TIMEOUT and a timeout returns BRG_ERR_DATA and sets
//   the sticky err flag. All outputs are registered.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     io_addr/read/write_strobe  : MCS strobes
//     io_address, io_byte_enable : MCS byte address and lanes
//     io_write_data              : MCS write data
//     io_read_data, io_ready     : registered read data, one-cycle completion
//     fp_cs                      : one-hot region select, held ACCESS..WAIT
//     fp_wr, fp_rd               : one-cycle access pulses in ACCESS
//     fp_be, fp_addr, fp_wr_data : held lanes, word address, write data
//     fp_rd_data                 : per-region read data, 32 bits per region
//     fp_rdy                     : per-region ready
//     err, err_clr               : sticky timeout flag and its clear
module mcs_fpro_bridge_mc
  import mcs_brg_pkg::*;
#(
  parameter logic [31:0] BRG_BASE = 32'hc000_0000,
  parameter int          N_CS     = 2,
  parameter int          RD_WAIT  = 0,
  parameter int          TIMEOUT  = 255,
  localparam int         CSW      = $clog2(N_CS),
  localparam int         AW       = 22 - CSW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_addr_strobe,
  input  logic              io_read_strobe,
  input  logic              io_write_strobe,
  input  logic [31:0]       io_address,
  input  logic [3:0]        io_byte_enable,
  input  logic [31:0]       io_write_data,
  output logic [31:0]       io_read_data,
  output logic              io_ready,
  output logic [N_CS-1:0]   fp_cs,
  output logic              fp_wr,
  output logic              fp_rd,
  output logic [3:0]        fp_be,
  output logic [AW-1:0]     fp_addr,
  output logic [31:0]       fp_wr_data,
  input  logic [32*N_CS-1:0] fp_rd_data,
  input  logic [N_CS-1:0]   fp_rdy,
  output logic              err,
  input  logic              err_clr
);

  brg_state_t       state;
  logic [CSW-1:0]   region;
  logic             is_wr;

  logic             hit;
  logic [CSW-1:0]   hit_idx;
  logic [31:0]      rd_slice;
  logic             rdy_sel;
  logic             rdw_ok;
  logic             tmo;

  // Direction comes from io_write_strobe alone; the read strobe and the
  // byte-offset bits carry no extra information for this bus.
  logic unused_in;
  assign unused_in = &{1'b0, io_read_strobe, io_address[1:0]};

  assign hit      = (io_address[31:24] == BRG_BASE[31:24]);
  assign hit_idx  = CSW'(brg_region_idx(io_address, CSW));
  assign rd_slice = fp_rd_data[{region, 5'd0} +: 32];
  assign rdy_sel  = fp_rdy[region];

  brg_wait_timer #(
    .RD_WAIT (RD_WAIT),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (state == ACCESS),
    .en        (state == WAIT),
    .ge_rdwait (rdw_ok),
    .timeout   (tmo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      region       <= '0;
      is_wr        <= 1'b0;
      io_read_data <= '0;
      io_ready     <= 1'b0;
      fp_cs        <= '0;
      fp_wr        <= 1'b0;
      fp_rd        <= 1'b0;
      fp_be        <= '0;
      fp_addr      <= '0;
      fp_wr_data   <= '0;
      err          <= 1'b0;
    end else begin
      fp_wr    <= 1'b0;
      fp_rd    <= 1'b0;
      io_ready <= 1'b0;

      // A timeout assignment further down overrides this clear in the same
      // cycle, so a set always wins over err_clr.
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (io_addr_strobe) begin
            if (hit) begin
              region     <= hit_idx;
              is_wr      <= io_write_strobe;
              fp_addr    <= io_address[23-CSW:2];
              fp_be      <= io_byte_enable;
              fp_wr_data <= io_write_data;
              fp_cs      <= N_CS'(1) << hit_idx;
              fp_wr      <= io_write_strobe;
              fp_rd      <= !io_write_strobe;
              state      <= ACCESS;
            end else begin
              io_read_data <= '0;
              io_ready     <= 1'b1;
              state        <= DONE;
            end
          end
        end

        ACCESS: begin
          state <= WAIT;
        end

        WAIT: begin
          if (rdy_sel && (is_wr || rdw_ok)) begin
            io_read_data <= is_wr ? 32'd0 : rd_slice;
            io_ready     <= 1'b1;
            fp_cs        <= '0;
            state        <= DONE;
          end else if (tmo) begin
            io_read_data <= BRG_ERR_DATA;
            io_ready     <= 1'b1;
            err          <= 1'b1;
            fp_cs        <= '0;
            state        <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs_fpro_bridge_mc.sv
// tb_mcs_fpro_bridge_mc
//   Two bridges share one stimulus stream: dut0 (N_CS=4, RD_WAIT=0,
//   TIMEOUT=8) and dut1 (N_CS=4, RD_WAIT=3, TIMEOUT=8). Each access pushes
//   the expected completion (data, cycle stamp, err) per bridge; a negedge
//   monitor pops and compares whenever io_ready is seen.
module tb_mcs_fpro_bridge_mc;

  logic         clk = 1'b0;
  logic         reset;
  logic         io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [31:0]  io_address, io_write_data;
  logic [3:0]   io_byte_enable;
  logic [127:0] fp_rd_data;
  logic [3:0]   fp_rdy;
  logic         err_clr;

  logic [31:0]  rdata0, wdata0, rdata1, wdata1;
  logic         ready0, wr0, rd0, err0, ready1, wr1, rd1, err1;
  logic [3:0]   cs0, be0, cs1, be1;
  logic [19:0]  addr0, addr1;

  typedef struct {
    logic [31:0] data;
    int          stamp;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt0 = 0;
  int wr_cnt0 = 0;
  int rdy_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcs_fpro_bridge_mc #(.N_CS(4), .RD_WAIT(0), .TIMEOUT(8)) u_dut0 (
    .clk(clk), .reset(reset),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(rdata0), .io_ready(ready0), .fp_cs(cs0), .fp_wr(wr0),
    .fp_rd(rd0), .fp_be(be0), .fp_addr(addr0), .fp_wr_data(wdata0),
    .fp_rd_data(fp_rd_data), .fp_rdy(fp_rdy), .err(err0), .err_clr(err_clr)
  );

  mcs_fpro_bridge_mc #(.N_CS(4), .RD_WAIT(3), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .reset(reset),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(rdata1), .io_ready(ready1), .fp_cs(cs1), .fp_wr(wr1),
    .fp_rd(rd1), .fp_be(be1), .fp_addr(addr1), .fp_wr_data(wdata1),
    .fp_rd_data(fp_rd_data), .fp_rdy(fp_rdy), .err(err1), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every io_ready must match a queued expectation.
  always @(negedge clk) begin
    if (rd0) rd_cnt0++;
    if (wr0) wr_cnt0++;
    if (ready0) begin
      rdy_cnt++;
      check("ready0_expected", 64'(q0.size() > 0), 64'd1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("ready0_data", 64'(rdata0), 64'(e0.data));
        check("ready0_cycle", 64'(cyc), 64'(e0.stamp));
        check("ready0_err", 64'(err0), 64'(e0.err));
      end
    end
    if (ready1) begin
      rdy_cnt++;
      check("ready1_expected", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("ready1_data", 64'(rdata1), 64'(e1.data));
        check("ready1_cycle", 64'(cyc), 64'(e1.stamp));
        check("ready1_err", 64'(err1), 64'(e1.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d0, input int s0,
                      input logic [31:0] d1, input int s1, input logic e);
    q0.push_back('{data: d0, stamp: s0, err: e});
    q1.push_back('{data: d1, stamp: s1, err: e});
  endtask

  task automatic set_strobe(input logic [31:0] a, input logic w,
                            input logic [31:0] wd, input logic [3:0] be);
    io_addr_strobe  = 1'b1;
    io_write_strobe = w;
    io_read_strobe  = !w;
    io_address      = a;
    io_write_data   = wd;
    io_byte_enable  = be;
  endtask

  task automatic clr_strobe();
    io_addr_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    io_read_strobe  = 1'b0;
  endtask

  task automatic start(input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] be);
    set_strobe(a, w, wd, be);
    tick();
    clr_strobe();
  endtask

  // Bounded wait until both bridges have delivered every queued completion.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    check(tag, 64'(q0.size() + q1.size()), 64'd0);
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data0"}, {rdata0, wdata0}, 64'd0);
    check({tag, "_ctrl0"}, 64'({ready0, cs0, wr0, rd0, be0, addr0, err0}), 64'd0);
    check({tag, "_data1"}, {rdata1, wdata1}, 64'd0);
    check({tag, "_ctrl1"}, 64'({ready1, cs1, wr1, rd1, be1, addr1, err1}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, r, w, n;
    reset = 1'b1;
    clr_strobe();
    io_address     = '0;
    io_write_data  = '0;
    io_byte_enable = '0;
    err_clr        = 1'b0;
    fp_rdy         = 4'hF;
    fp_rd_data     = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0BAD_0000};

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Read region 1; slice 1 changes every cycle so dut0 captures the cycle-2
    // value and dut1 (RD_WAIT=3) the cycle-5 value.
    k = cyc;
    r = rd_cnt0;
    push(32'h1234_5678, k + 3, 32'h1234_567B, k + 6, 1'b0);
    for (int c = 0; c < 8; c++) begin
      fp_rd_data[63:32] = 32'h1234_5676 + 32'(c);
      if (c == 0) set_strobe(32'hc040_0010, 1'b0, 32'd0, 4'hF);
      if (c == 1) begin
        clr_strobe();
        @(negedge clk);
        check("rd_cs", 64'(cs0), 64'h2);
        check("rd_addr", 64'(addr0), 64'd4);
        check("rd_pulse", 64'(rd0), 64'd1);
      end
      tick();
    end
    drain("rd_drain");
    check("rd_pulse_count", 64'(rd_cnt0 - r), 64'd1);
    fp_rd_data[63:32] = 32'h1111_0001;

    // Write region 0 with fp_rdy[0] low for five WAIT cycles
    k = cyc;
    w = wr_cnt0;
    fp_rdy = 4'b1110;
    push(32'd0, k + 8, 32'd0, k + 8, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) set_strobe(32'hc000_0020, 1'b1, 32'hA5A5_0000, 4'b1100);
      if (c == 1) clr_strobe();
      if (c == 7) fp_rdy = 4'hF;
      if (c == 1 || c == 6) begin
        @(negedge clk);
        check("wr_cs", 64'(cs0), 64'h1);
        check("wr_be", 64'(be0), 64'hC);
        check("wr_data", 64'(wdata0), 64'hA5A5_0000);
        check("wr_addr", 64'(addr0), 64'd8);
        check("wr_pulse_level", 64'(wr0), (c == 1) ? 64'd1 : 64'd0);
      end
      tick();
    end
    drain("wr_drain");
    check("wr_pulse_count", 64'(wr_cnt0 - w), 64'd1);

    // Timeout with fp_rdy stuck low
    fp_rdy = 4'h0;
    k = cyc;
    push(32'hDEAD_BEEF, k + 11, 32'hDEAD_BEEF, k + 11, 1'b1);
    start(32'hc080_0000, 1'b0, 32'd0, 4'hF);
    drain("tmo1_drain");
    @(negedge clk);
    check("tmo1_err_sticky", 64'({err0, err1}), 64'h3);

    // Second timeout with err_clr held through the timeout cycle
    k = cyc;
    push(32'hDEAD_BEEF, k + 11, 32'hDEAD_BEEF, k + 11, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        set_strobe(32'hc080_0000, 1'b0, 32'd0, 4'hF);
        err_clr = 1'b1;
      end
      if (c == 1) clr_strobe();
      if (c == 5) begin
        @(negedge clk);
        check("tmo2_err_cleared_mid", 64'({err0, err1}), 64'h0);
      end
      if (c == 11) err_clr = 1'b0;
      tick();
    end
    drain("tmo2_drain");
    @(negedge clk);
    check("tmo2_set_wins", 64'({err0, err1}), 64'h3);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr_alone", 64'({err0, err1}), 64'h0);
    fp_rdy = 4'hF;
    tick();

    // Miss: immediate completion, no fp activity
    k = cyc;
    push(32'd0, k + 1, 32'd0, k + 1, 1'b0);
    start(32'h8000_0000, 1'b0, 32'd0, 4'hF);
    @(negedge clk);
    check("miss_fp_c1", 64'({cs0, rd0, cs1, rd1}), 64'd0);
    tick();
    @(negedge clk);
    check("miss_fp_c2", 64'({cs0, rd0, cs1, rd1}), 64'd0);
    drain("miss_drain");

    // Reset during WAIT aborts silently, next access completes
    fp_rdy = 4'h0;
    n = rdy_cnt;
    start(32'hc0c0_0004, 1'b0, 32'd0, 4'hF);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    repeat (12) tick();
    check("rst_mid_no_ready", 64'(rdy_cnt - n), 64'd0);
    fp_rdy = 4'hF;
    k = cyc;
    push(32'h3333_0003, k + 3, 32'h3333_0003, k + 6, 1'b0);
    start(32'hc0c0_0004, 1'b0, 32'd0, 4'hF);
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
